// File: rtl/dsp_add_arbiter_pkg.sv
// Shared constants, operand payload type and 33-bit add helper for the DSP adder arbiter.
// The packed-operand slice macro selects requester i's 32-bit lane from a packed bus.
`ifndef DSP_ADD_ARB_SLICE
`define DSP_ADD_ARB_SLICE(bus, i) bus[(i)*32 +: 32]
`endif

package dsp_add_arbiter_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MAX_LATENCY = 3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } add_op_t;

  // Two 16-bit halves with the low-half carry chained into the high half.
  function automatic logic [DATA_W:0] add33(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic              op);
    logic [DATA_W-1:0] bx;
    logic [16:0]       lo;
    logic [16:0]       hi;
    bx = (op == OP_SUB) ? ~b : b;
    lo = {1'b0, a[15:0]} + {1'b0, bx[15:0]} + 17'(op == OP_SUB);
    hi = {1'b0, a[31:16]} + {1'b0, bx[31:16]} + 17'(lo[16]);
    return {hi, lo[15:0]};
  endfunction

endpackage

// File: rtl/dsp_add32_pipe.sv
// Pipelined 32-bit add/sub modelled on SB_MAC16 in 16+16 add mode.
// LATENCY 1: output reg only; 2: input + output regs; 3: input, low-half mid stage, output regs.
module dsp_add32_pipe
  import dsp_add_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LATENCY-1:0] stage_en,
  input  add_op_t            op_in,
  output logic [DATA_W-1:0]  data,
  output logic               carry
);

  logic [DATA_W:0] res_q;

  if (LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
      end else if (stage_en[0]) begin
        res_q <= add33(op_in.a, op_in.b, op_in.op);
      end
    end
  end else begin : g_lat23
    add_op_t in_q;

    // Operand registers (A/B/C/D inputs of the DSP tile).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        in_q <= '0;
      end else if (stage_en[0]) begin
        in_q <= op_in;
      end
    end

    if (LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (stage_en[1]) begin
          res_q <= add33(in_q.a, in_q.b, in_q.op);
        end
      end
    end else begin : g_lat3
      logic [DATA_W-1:0] bx_c;
      logic [16:0]       lo_q;
      logic [15:0]       a_hi_q;
      logic [15:0]       b_hi_q;

      assign bx_c = (in_q.op == OP_SUB) ? ~in_q.b : in_q.b;

      // Mid stage resolves the low half; its carry feeds the high half next cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_q   <= '0;
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (stage_en[1]) begin
          lo_q   <= {1'b0, in_q.a[15:0]} + {1'b0, bx_c[15:0]} + 17'(in_q.op == OP_SUB);
          a_hi_q <= in_q.a[31:16];
          b_hi_q <= bx_c[31:16];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (stage_en[2]) begin
          res_q <= {({1'b0, a_hi_q} + {1'b0, b_hi_q} + 17'(lo_q[16])), lo_q[15:0]};
        end
      end
    end
  end

  assign data  = res_q[DATA_W-1:0];
  assign carry = res_q[DATA_W];

endmodule

// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined DSP adder among NUM_REQ requesters.
// Optional macro DSP_ADD_ARB_PRIO0_EN gives requester 0 absolute priority.
module dsp_add_arbiter
  import dsp_add_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_sub,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_carry,
  output logic                      busy
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY || NUM_REQ < 2 || NUM_REQ > 8 ||
      (2 ** ID_W) < NUM_REQ) begin : g_bad_param
    $error("dsp_add_arbiter: unsupported NUM_REQ/ID_W/LATENCY combination");
  end

  logic [ID_W-1:0]           rr_ptr;
  logic [NUM_REQ-1:0]        rr_gnt_c;
  logic [ID_W-1:0]           rr_id_c;
  logic [NUM_REQ-1:0]        gnt_c;
  logic [ID_W-1:0]           gnt_id_c;
  logic                      fire_c;
  logic                      ptr_upd_c;
  add_op_t                   sel_c;
  logic [LATENCY-1:0]        pipe_v;
  logic [LATENCY-1:0]        v_in_c;
  logic [LATENCY-1:0][ID_W-1:0] pipe_id;
  logic [LATENCY-1:0][ID_W-1:0] id_in_c;

  // Closest valid requester at or after rr_ptr, modulo NUM_REQ.
  always_comb begin : rr_search
    int unsigned off;
    int unsigned best;
    int unsigned pick;
    rr_gnt_c = '0;
    rr_id_c  = '0;
    best     = NUM_REQ;
    pick     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - 32'(rr_ptr)) % NUM_REQ;
      if (req_valid[i] && off < best) begin
        best = off;
        pick = i;
      end
    end
    if (best < NUM_REQ) begin
      rr_gnt_c = NUM_REQ'(1) << pick;
      rr_id_c  = ID_W'(pick);
    end
  end

  always_comb begin
    gnt_c     = rr_gnt_c;
    gnt_id_c  = rr_id_c;
    ptr_upd_c = 1'b1;
`ifdef DSP_ADD_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt_c    = NUM_REQ'(1);
      gnt_id_c = '0;
    end
    ptr_upd_c = (gnt_id_c != '0);
`endif
  end

  assign req_ready = gnt_c & {NUM_REQ{rst_n & ~flush}};
  assign fire_c    = |req_ready;

  always_comb begin
    sel_c = '{op: OP_ADD, a: '0, b: '0};
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_c = '{op: req_sub[i], a: `DSP_ADD_ARB_SLICE(req_a, i), b: `DSP_ADD_ARB_SLICE(req_b, i)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (fire_c && ptr_upd_c) begin
      rr_ptr <= (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
    end
  end

  // Tag pipe inputs: stage 0 takes the new issue, later stages shift.
  always_comb begin
    v_in_c[0]  = fire_c;
    id_in_c[0] = gnt_id_c;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      v_in_c[k]  = pipe_v[k-1];
      id_in_c[k] = pipe_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v  <= '0;
      pipe_id <= '0;
      busy    <= 1'b0;
    end else begin
      pipe_v <= flush ? '0 : v_in_c;
      busy   <= ~flush & (|v_in_c);
      for (int unsigned k = 0; k < LATENCY; k++) begin
        if (v_in_c[k]) begin
          pipe_id[k] <= id_in_c[k];
        end
      end
    end
  end

  dsp_add32_pipe #(
    .LATENCY (LATENCY)
  ) u_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .stage_en (v_in_c & {LATENCY{~flush}}),
    .op_in    (sel_c),
    .data     (resp_data),
    .carry    (resp_carry)
  );

  assign resp_valid = pipe_v[LATENCY-1];
  assign resp_id    = pipe_id[LATENCY-1];

endmodule
